// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch types and constants.
package rv32i_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered queue of fetched {pc, instr} entries with synchronous flush.
// The head output holds its last shown value while the queue is empty.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter type         entry_t    = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_flush,
  input  entry_t i_wdata,
  output entry_t o_rdata,
  output logic   o_full,
  output logic   o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            r_mem [FIFO_DEPTH];
  entry_t            r_last;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_last   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (!o_empty) begin
        r_last <= r_mem[r_rd_ptr];
      end
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (i_push) begin
          r_mem[r_wr_ptr] <= i_wdata;
          r_wr_ptr        <= r_wr_ptr + PtrW'(1);
        end
        if (i_pop) begin
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end
        r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
      end
    end
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(FIFO_DEPTH));
  assign o_count = r_count;
  // Once drained, keep presenting the most recently shown head entry.
  assign o_rdata = o_empty ? r_last : r_mem[r_rd_ptr];

`ifndef SYNTHESIS
  count_bound_a : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= CntW'(FIFO_DEPTH));
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational ROM and queues {pc, instr}
// towards decode; redirects flush the queue and reload the PC.
module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instruction_memory_address,
  input  logic [DATA_WIDTH-1:0] instruction_memory_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_target,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] fetch_instruction,
  output logic [31:0]           fetch_pc,
  output logic                  misaligned_redirect
);

  logic [31:0]                 r_pc;
  logic                        r_misaligned;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_unused_count;
  fetch_entry_t                w_wdata;
  fetch_entry_t                w_rdata;

  assign instruction_memory_address = r_pc[ADDR_WIDTH+1:2];

  assign w_pop  = fetch_valid && fetch_ready;
  // A full queue still accepts a push when its head leaves in the same cycle.
  assign w_push = !redirect_valid && (!w_full || w_pop);

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = instruction_memory_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (redirect_valid) begin
        r_pc <= {redirect_target[31:2], 2'b00};
      end else if (w_push) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .entry_t    (fetch_entry_t)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_unused_count)
  );

  assign fetch_valid         = !w_empty;
  assign fetch_pc            = w_rdata.pc;
  assign fetch_instruction   = w_rdata.instr;
  assign misaligned_redirect = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic against
// a queue-based reference model of the fetch stage.
module tb_instruction_fetch;
  import rv32i_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        misaligned_redirect;

  int total = 0;
  int bad   = 0;

  // Reference model state
  fetch_entry_t q[$];
  fetch_entry_t m_shown;
  logic [31:0]  m_pc;
  logic         m_mis;
  logic [31:0]  popped[$];

  instruction_fetch dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .instruction_memory_address (rom_addr),
    .instruction_memory_data    (rom_data),
    .redirect_valid             (redirect_valid),
    .redirect_target            (redirect_target),
    .fetch_valid                (fetch_valid),
    .fetch_ready                (fetch_ready),
    .fetch_instruction          (fetch_instruction),
    .fetch_pc                   (fetch_pc),
    .misaligned_redirect        (misaligned_redirect)
  );

  assign rom_data = {20'h0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    popped.delete();
    m_shown = '0;
    m_pc    = 32'h0;
    m_mis   = 1'b0;
  endtask

  task automatic model_update(input logic rv, input logic [31:0] tgt, input logic rdy);
    fetch_entry_t e;
    logic pop;
    pop = (q.size() != 0) && rdy;
    if (rv) begin
      q.delete();
      m_pc  = tgt & 32'hFFFF_FFFC;
      m_mis = (tgt % 4) != 0;
    end else begin
      m_mis = 1'b0;
      if (pop) popped.push_back(q.pop_front().pc);
      if (q.size() < DEPTH) begin
        e.pc    = m_pc;
        e.instr = (m_pc / 4) % 4096;
        q.push_back(e);
        m_pc = m_pc + 4;
      end
    end
    if (q.size() != 0) m_shown = q[0];
  endtask

  // Apply inputs at a falling edge, advance one rising edge, return at the next falling edge.
  task automatic step(input logic rv, input logic [31:0] tgt, input logic rdy);
    redirect_valid  = rv;
    redirect_target = tgt;
    fetch_ready     = rdy;
    @(posedge clk);
    model_update(rv, tgt, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    fetch_ready     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", fetch_pc); end
    total++; if (fetch_instruction !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", fetch_instruction); end
    total++; if (misaligned_redirect !== 1'b0) begin bad++; $display("FAIL rst_mis: got %b want 0", misaligned_redirect); end
    do_reset();
    total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL rst_addr: got %h want 000", rom_addr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_c0: got %b want 0", fetch_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h0, 1'b1);
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", k, fetch_valid); end
      total++; if (fetch_pc !== 32'(4 * k)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", k, fetch_pc, 4 * k); end
      total++; if (fetch_instruction !== 32'(k)) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", k, fetch_instruction, k); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pcs[4];
    exp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    repeat (5) step(1'b0, 32'h0, 1'b0);
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL stall_head: got %h want 0", fetch_pc); end
    total++; if (rom_addr !== 12'h002) begin bad++; $display("FAIL stall_addr: got %h want 002", rom_addr); end
    repeat (4) step(1'b0, 32'h0, 1'b1);
    total++; if (popped.size() != 4) begin bad++; $display("FAIL stall_npop: got %0d want 4", popped.size()); end
    for (int i = 0; i < 4 && i < popped.size(); i++) begin
      total++; if (popped[i] !== exp_pcs[i]) begin bad++; $display("FAIL stall_order[%0d]: got %h want %h", i, popped[i], exp_pcs[i]); end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    repeat (3) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b1);
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", fetch_valid); end
    total++; if (rom_addr !== 12'h010) begin bad++; $display("FAIL redir_addr: got %h want 010", rom_addr); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (fetch_pc !== 32'h40 || fetch_valid !== 1'b1) begin bad++; $display("FAIL redir_pc: got %h/%b want 00000040/1", fetch_pc, fetch_valid); end
    total++; if (fetch_instruction !== 32'h10) begin bad++; $display("FAIL redir_instr: got %h want 10", fetch_instruction); end
    total++; if (popped.size() != 0) begin bad++; $display("FAIL redir_stale_pop: got %0d pops want 0", popped.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 32'h3FFC, 1'b0);
    total++; if (rom_addr !== 12'hFFF) begin bad++; $display("FAIL wrap_addr_top: got %h want fff", rom_addr); end
    step(1'b0, 32'h0, 1'b0);
    total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL wrap_addr0: got %h want 000", rom_addr); end
    total++; if (fetch_instruction !== 32'hFFF) begin bad++; $display("FAIL wrap_instr_top: got %h want fff", fetch_instruction); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (fetch_pc !== 32'h4000 || fetch_instruction !== 32'h0) begin bad++; $display("FAIL wrap_head: got %h/%h want 00004000/0", fetch_pc, fetch_instruction); end
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL wrap32_addr: got %h want 000", rom_addr); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL wrap32_pc: got %h want 0", fetch_pc); end
  endtask

  task automatic test_misaligned();
    do_reset();
    step(1'b1, 32'h42, 1'b1);
    total++; if (misaligned_redirect !== 1'b1) begin bad++; $display("FAIL mis_pulse: got %b want 1", misaligned_redirect); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (misaligned_redirect !== 1'b0) begin bad++; $display("FAIL mis_clear: got %b want 0", misaligned_redirect); end
    total++; if (fetch_pc !== 32'h40) begin bad++; $display("FAIL mis_pc: got %h want 40", fetch_pc); end
    step(1'b1, 32'h80, 1'b1);
    total++; if (misaligned_redirect !== 1'b0) begin bad++; $display("FAIL mis_aligned: got %b want 0", misaligned_redirect); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) step(1'b0, 32'h0, 1'b0);
    #2;
    rst_n           = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", fetch_valid); end
    total++; if (fetch_pc !== 32'h0 || fetch_instruction !== 32'h0) begin bad++; $display("FAIL mid_head: got %h/%h want 0/0", fetch_pc, fetch_instruction); end
    total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL mid_addr: got %h want 000", rom_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    rst_n          = 1'b1;
    model_reset();
    total++; if (misaligned_redirect !== 1'b0) begin bad++; $display("FAIL mid_mis: got %b want 0", misaligned_redirect); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (fetch_pc !== 32'h0 || fetch_valid !== 1'b1) begin bad++; $display("FAIL mid_restart: got %h/%b want 0/1", fetch_pc, fetch_valid); end
  endtask

  task automatic test_random();
    logic        rv;
    logic        rdy;
    logic [31:0] tgt;
    logic [31:0] prev_pc;
    logic        chain;
    int          n;
    do_reset();
    chain   = 1'b0;
    prev_pc = '0;
    for (int it = 0; it < 400; it++) begin
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = $urandom;
      n   = popped.size();
      step(rv, tgt, rdy);
      if (rv) chain = 1'b0;
      total++; if (fetch_valid !== (q.size() != 0)) begin bad++; $display("FAIL rand_valid[%0d]: got %b want %b", it, fetch_valid, q.size() != 0); end
      total++; if (fetch_pc !== m_shown.pc) begin bad++; $display("FAIL rand_pc[%0d]: got %h want %h", it, fetch_pc, m_shown.pc); end
      total++; if (fetch_instruction !== m_shown.instr) begin bad++; $display("FAIL rand_instr[%0d]: got %h want %h", it, fetch_instruction, m_shown.instr); end
      total++; if (rom_addr !== m_pc[13:2]) begin bad++; $display("FAIL rand_addr[%0d]: got %h want %h", it, rom_addr, m_pc[13:2]); end
      total++; if (misaligned_redirect !== m_mis) begin bad++; $display("FAIL rand_mis[%0d]: got %b want %b", it, misaligned_redirect, m_mis); end
      if (popped.size() > n) begin
        if (chain) begin
          total++; if (popped[$] !== prev_pc + 32'd4) begin bad++; $display("FAIL rand_pop_step[%0d]: got %h want %h", it, popped[$], prev_pc + 32'd4); end
        end
        prev_pc = popped[$];
        chain   = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    fetch_ready     = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
